// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and defaults for the Wishbone master bridge
package wb_pkg;

    localparam int WB_AW              = 32;
    localparam int WB_DW              = 32;
    localparam int WB_TIMEOUT_CYCLES  = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_state_t;

    function automatic int sel_width(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/wb_master_bridge_if.sv
// rtl/wb_master_bridge_if.sv - command, response and Wishbone signals of the bridge
interface wb_master_bridge_if
    import wb_pkg::*;
#(
    parameter int AW = WB_AW,
    parameter int DW = WB_DW
);
    localparam int SW = sel_width(DW);

    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic          cmd_we_i;
    logic [AW-1:0] cmd_adr_i;
    logic [DW-1:0] cmd_dat_i;
    logic [SW-1:0] cmd_sel_i;

    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [DW-1:0] rsp_dat_o;
    logic          rsp_err_o;

    logic          wbm_cyc_o;
    logic          wbm_stb_o;
    logic          wbm_we_o;
    logic [AW-1:0] wbm_adr_o;
    logic [DW-1:0] wbm_dat_o;
    logic [SW-1:0] wbm_sel_o;
    logic [DW-1:0] wbm_dat_i;
    logic          wbm_ack_i;
    logic          wbm_err_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        input  rsp_ready_i, wbm_dat_i, wbm_ack_i, wbm_err_i,
        output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        output rsp_ready_i, wbm_dat_i, wbm_ack_i, wbm_err_i,
        input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
    );

endinterface

// File: rtl/wb_timeout_ctr.sv
// rtl/wb_timeout_ctr.sv - bus-cycle watchdog: load, count while active, flag expiry
module wb_timeout_ctr #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic count,
    output logic expire
);
    localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            cnt <= '0;
        end else if (count) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Expiry is seen while sampling the LIMIT-th bus cycle, so the abort lands after exactly LIMIT cycles.
    assign expire = count && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/wb_master_bridge.sv
// rtl/wb_master_bridge.sv - single-outstanding Wishbone B4 classic initiator; optional watchdog via WB_TIMEOUT_EN
module wb_master_bridge
    import wb_pkg::*;
#(
    parameter int AW = WB_AW,
    parameter int DW = WB_DW
`ifdef WB_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = WB_TIMEOUT_CYCLES
`endif
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    wb_master_bridge_if.master   bus
);
    localparam int SW = sel_width(DW);

    wb_state_t     state, state_nxt;
    logic          cmd_ready, cmd_ready_nxt;
    logic          rsp_valid, rsp_valid_nxt;
    logic [DW-1:0] rsp_dat, rsp_dat_nxt;
    logic          rsp_err, rsp_err_nxt;
    logic          cyc, cyc_nxt;
    logic          stb, stb_nxt;
    logic          we, we_nxt;
    logic [AW-1:0] adr, adr_nxt;
    logic [DW-1:0] dat, dat_nxt;
    logic [SW-1:0] sel, sel_nxt;
    logic          expire;
    logic          abort;

`ifdef WB_TIMEOUT_EN
    wb_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk_i),
        .rst    (rst_i),
        .load   (state != BUS),
        .count  (state == BUS),
        .expire (expire)
    );
`else
    assign expire = 1'b0;
`endif

    // ERR beats ACK; a timeout only counts when no ACK arrives in the same cycle.
    assign abort = bus.wbm_err_i || (expire && !bus.wbm_ack_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
            cyc       <= 1'b0;
            stb       <= 1'b0;
            we        <= 1'b0;
            adr       <= '0;
            dat       <= '0;
            sel       <= '0;
        end else begin
            state     <= state_nxt;
            cmd_ready <= cmd_ready_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_dat   <= rsp_dat_nxt;
            rsp_err   <= rsp_err_nxt;
            cyc       <= cyc_nxt;
            stb       <= stb_nxt;
            we        <= we_nxt;
            adr       <= adr_nxt;
            dat       <= dat_nxt;
            sel       <= sel_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cmd_ready_nxt = cmd_ready;
        rsp_valid_nxt = rsp_valid;
        rsp_dat_nxt   = rsp_dat;
        rsp_err_nxt   = rsp_err;
        cyc_nxt       = cyc;
        stb_nxt       = stb;
        we_nxt        = we;
        adr_nxt       = adr;
        dat_nxt       = dat;
        sel_nxt       = sel;

        case (state)
            IDLE: begin
                cmd_ready_nxt = 1'b1;
                if (bus.cmd_valid_i) begin
                    state_nxt     = BUS;
                    cmd_ready_nxt = 1'b0;
                    cyc_nxt       = 1'b1;
                    stb_nxt       = 1'b1;
                    we_nxt        = bus.cmd_we_i;
                    adr_nxt       = bus.cmd_adr_i;
                    dat_nxt       = bus.cmd_we_i ? bus.cmd_dat_i : '0;
                    sel_nxt       = bus.cmd_sel_i;
                end
            end

            BUS: begin
                if (bus.wbm_ack_i || abort) begin
                    state_nxt     = RESP;
                    cyc_nxt       = 1'b0;
                    stb_nxt       = 1'b0;
                    we_nxt        = 1'b0;
                    sel_nxt       = '0;
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = abort;
                    rsp_dat_nxt   = (abort || we) ? '0 : bus.wbm_dat_i;
                end
            end

            RESP: begin
                if (bus.rsp_ready_i) begin
                    state_nxt     = IDLE;
                    rsp_valid_nxt = 1'b0;
                    rsp_dat_nxt   = '0;
                    rsp_err_nxt   = 1'b0;
                    cmd_ready_nxt = 1'b1;
                end
            end

            default: begin
                state_nxt     = IDLE;
                cmd_ready_nxt = 1'b1;
                rsp_valid_nxt = 1'b0;
                cyc_nxt       = 1'b0;
                stb_nxt       = 1'b0;
            end
        endcase
    end

    assign bus.cmd_ready_o = cmd_ready;
    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_dat_o   = rsp_dat;
    assign bus.rsp_err_o   = rsp_err;
    assign bus.wbm_cyc_o   = cyc;
    assign bus.wbm_stb_o   = stb;
    assign bus.wbm_we_o    = we;
    assign bus.wbm_adr_o   = adr;
    assign bus.wbm_dat_o   = dat;
    assign bus.wbm_sel_o   = sel;

endmodule

// File: tb/tb_wb_master_bridge.sv
// tb/tb_wb_master_bridge.sv - directed self-checking bench for wb_master_bridge (WB_TIMEOUT_EN aware)
module tb_wb_master_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          vecs = 0;
    int          miss = 0;
    int          cyc_hi;
    logic [31:0] slave_reg = 32'h0;

    wb_master_bridge_if #(.AW(32), .DW(32)) bus ();

    wb_master_bridge #(
        .AW (32),
        .DW (32)
`ifdef WB_TIMEOUT_EN
        , .TIMEOUT_CYCLES (8)
`endif
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i    = we;
        bus.cmd_adr_i   = adr;
        bus.cmd_dat_i   = dat;
        bus.cmd_sel_i   = sel;
    endtask

    task automatic slave_write;
        for (int b = 0; b < 4; b++)
            if (bus.wbm_sel_o[b]) slave_reg[8*b +: 8] = bus.wbm_dat_o[8*b +: 8];
    endtask

    task automatic handoff(input string tag);
        bus.rsp_ready_i = 1'b1;
        tick();
        bus.rsp_ready_i = 1'b0;
        chk({tag, "_rsp_valid_clr"}, 64'(bus.rsp_valid_o), 64'd0);
        chk({tag, "_cmd_ready_set"}, 64'(bus.cmd_ready_o), 64'd1);
    endtask

    initial begin
        bus.cmd_valid_i = 1'b0;
        bus.cmd_we_i    = 1'b0;
        bus.cmd_adr_i   = '0;
        bus.cmd_dat_i   = '0;
        bus.cmd_sel_i   = '0;
        bus.rsp_ready_i = 1'b0;
        bus.wbm_dat_i   = '0;
        bus.wbm_ack_i   = 1'b0;
        bus.wbm_err_i   = 1'b0;

        tick();
        tick();
        rst = 1'b0;
        chk("rst_cmd_ready", 64'(bus.cmd_ready_o), 64'd1);
        chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        chk("rst_rsp_dat",   64'(bus.rsp_dat_o),   64'd0);
        chk("rst_rsp_err",   64'(bus.rsp_err_o),   64'd0);
        chk("rst_cyc_stb",   {62'd0, bus.wbm_cyc_o, bus.wbm_stb_o}, 64'd0);
        chk("rst_we_sel",    {59'd0, bus.wbm_we_o, bus.wbm_sel_o}, 64'd0);
        chk("rst_adr_dat",   {bus.wbm_adr_o, bus.wbm_dat_o}, 64'd0);

        // 1: write, ACK on the second bus cycle
        send(1'b1, 32'h3000_0000, 32'hA5A5_1234, 4'hF);
        tick();
        bus.cmd_valid_i = 1'b0;
        cyc_hi = 0;
        chk("w_cyc_stb", {62'd0, bus.wbm_cyc_o, bus.wbm_stb_o}, 64'd3);
        chk("w_we_sel",  {59'd0, bus.wbm_we_o, bus.wbm_sel_o}, 64'h1F);
        chk("w_adr_dat", {bus.wbm_adr_o, bus.wbm_dat_o}, 64'h3000_0000_A5A5_1234);
        chk("w_cmd_ready_low", 64'(bus.cmd_ready_o), 64'd0);
        if (bus.wbm_cyc_o) cyc_hi++;
        tick();
        if (bus.wbm_cyc_o) cyc_hi++;
        chk("w_rsp_not_yet", 64'(bus.rsp_valid_o), 64'd0);
        bus.wbm_ack_i = 1'b1;
        slave_write();
        tick();
        bus.wbm_ack_i = 1'b0;
        if (bus.wbm_cyc_o) cyc_hi++;
        chk("w_cyc_cycles", 64'(cyc_hi), 64'd2);
        chk("w_rsp", {bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_dat_o}, {32'd0, 1'b1, 1'b0, 32'h0});
        chk("w_we_sel_clr", {59'd0, bus.wbm_we_o, bus.wbm_sel_o}, 64'd0);
        handoff("w");

        // 2: read with three wait states
        send(1'b0, 32'h3000_0004, 32'hFFFF_FFFF, 4'hF);
        tick();
        bus.cmd_valid_i = 1'b0;
        chk("r_dat_o_zero", 64'(bus.wbm_dat_o), 64'd0);
        for (int i = 0; i < 3; i++) begin
            chk("r_stb_adr_hold", {31'd0, bus.wbm_stb_o, bus.wbm_adr_o}, 64'h1_3000_0004);
            tick();
        end
        chk("r_stb_adr_hold4", {31'd0, bus.wbm_stb_o, bus.wbm_adr_o}, 64'h1_3000_0004);
        bus.wbm_ack_i = 1'b1;
        bus.wbm_dat_i = 32'hDEAD_BEEF;
        tick();
        bus.wbm_ack_i = 1'b0;
        bus.wbm_dat_i = 32'h0;
        chk("r_rsp", {bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_dat_o}, {32'd0, 1'b1, 1'b0, 32'hDEAD_BEEF});
        handoff("r");

        // 3: single-byte write
        send(1'b1, 32'h3000_0000, 32'h00CC_0000, 4'b0100);
        tick();
        bus.cmd_valid_i = 1'b0;
        chk("b_sel", 64'(bus.wbm_sel_o), 64'h4);
        tick();
        chk("b_sel_hold", 64'(bus.wbm_sel_o), 64'h4);
        bus.wbm_ack_i = 1'b1;
        slave_write();
        tick();
        bus.wbm_ack_i = 1'b0;
        chk("b_slave_reg", 64'(slave_reg), 64'hA5CC_1234);
        handoff("b");

        // 4: ERR alone, then ACK+ERR together
        send(1'b0, 32'h3000_0010, 32'h0, 4'hF);
        tick();
        bus.cmd_valid_i = 1'b0;
        bus.wbm_err_i = 1'b1;
        bus.wbm_dat_i = 32'h1234_5678;
        tick();
        bus.wbm_err_i = 1'b0;
        chk("e_rsp", {bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_dat_o, bus.wbm_cyc_o}, {31'd0, 1'b1, 1'b1, 32'h0, 1'b0});
        handoff("e");
        send(1'b0, 32'h3000_0014, 32'h0, 4'hF);
        tick();
        bus.cmd_valid_i = 1'b0;
        bus.wbm_err_i = 1'b1;
        bus.wbm_ack_i = 1'b1;
        tick();
        bus.wbm_err_i = 1'b0;
        bus.wbm_ack_i = 1'b0;
        bus.wbm_dat_i = 32'h0;
        chk("ae_rsp", {bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_dat_o}, {32'd0, 1'b1, 1'b1, 32'h0});
        handoff("ae");
        send(1'b1, 32'h3000_0018, 32'h1, 4'hF);
        tick();
        bus.cmd_valid_i = 1'b0;
        chk("e_next_accepted", 64'(bus.wbm_cyc_o), 64'd1);
        bus.wbm_ack_i = 1'b1;
        tick();
        bus.wbm_ack_i = 1'b0;
        chk("e_next_rsp", {bus.rsp_valid_o, bus.rsp_err_o}, 64'h2);
        handoff("en");

        // 5: response backpressure, stray ACK and blocked command
        send(1'b0, 32'h3000_0020, 32'h0, 4'hF);
        tick();
        bus.wbm_ack_i = 1'b1;
        bus.wbm_dat_i = 32'h0BAD_F00D;
        tick();
        bus.wbm_ack_i = 1'b0;
        bus.wbm_dat_i = 32'h0;
        send(1'b1, 32'h3000_0008, 32'h7777_7777, 4'hF);
        for (int i = 0; i < 5; i++) begin
            bus.wbm_ack_i = (i == 2);
            tick();
            chk("bp_rsp_hold", {bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_dat_o}, {32'd0, 1'b1, 1'b0, 32'h0BAD_F00D});
            chk("bp_blocked", {62'd0, bus.cmd_ready_o, bus.wbm_cyc_o}, 64'd0);
        end
        bus.wbm_ack_i = 1'b0;
        handoff("bp");
        chk("bp_no_same_cycle_accept", 64'(bus.wbm_cyc_o), 64'd0);
        tick();
        bus.cmd_valid_i = 1'b0;
        chk("bp_accept_after", {31'd0, bus.wbm_cyc_o, bus.wbm_adr_o}, 64'h1_3000_0008);
        bus.wbm_ack_i = 1'b1;
        tick();
        bus.wbm_ack_i = 1'b0;
        handoff("bp2");

        // 6: reset mid-BUS and mid-RESP
        send(1'b0, 32'h3000_0030, 32'h0, 4'hF);
        tick();
        bus.cmd_valid_i = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rb_cyc_stb", {62'd0, bus.wbm_cyc_o, bus.wbm_stb_o}, 64'd0);
        chk("rb_rsp_ready", {62'd0, bus.rsp_valid_o, bus.cmd_ready_o}, 64'd1);
        send(1'b0, 32'h3000_0034, 32'h0, 4'hF);
        tick();
        bus.cmd_valid_i = 1'b0;
        bus.wbm_ack_i = 1'b1;
        tick();
        bus.wbm_ack_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rr_rsp_drop", {62'd0, bus.rsp_valid_o, bus.cmd_ready_o}, 64'd1);

`ifdef WB_TIMEOUT_EN
        send(1'b0, 32'h3000_0040, 32'h0, 4'hF);
        tick();
        bus.cmd_valid_i = 1'b0;
        bus.wbm_dat_i = 32'h5555_5555;
        for (int i = 0; i < 7; i++) begin
            chk("to_still_waiting", {62'd0, bus.wbm_cyc_o, bus.rsp_valid_o}, 64'h2);
            tick();
        end
        chk("to_last_wait", 64'(bus.wbm_cyc_o), 64'd1);
        tick();
        bus.wbm_dat_i = 32'h0;
        chk("to_abort", {bus.wbm_cyc_o, bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_dat_o}, {29'd0, 1'b0, 1'b1, 1'b1, 32'h0});
        handoff("to");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
